viterbi_decode: RTL and testbench

// Hard-decision Viterbi decoder for the rate-1/2, K=4 convolutional code in the BPSK chain.

---
 rtl/viterbi_decode.sv | 105 ++++++++++
 tb/tb_viterbi_decode.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decode.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=4 (octal 13/17) convolutional code.
// Eight-state add-compare-select with register-exchange survivors of depth TB_DEPTH.
module viterbi_decode #(
    parameter int TB_DEPTH = 20,
    parameter int METRIC_W = 6
) (
    input  logic       clk_sig,
    input  logic       rst_sig,
    input  logic [1:0] code_sig,
    input  logic       code_valid_sig,
    output logic       dec_sig,
    output logic       dec_valid_sig
);

    localparam int N_STATES = 8;
    localparam int FILL_W   = $clog2(TB_DEPTH + 1);

    typedef logic [METRIC_W-1:0] metric_t;
    typedef logic [TB_DEPTH-1:0] surv_t;

    metric_t             pm_q   [N_STATES];
    metric_t             pm_acs [N_STATES];
    metric_t             pm_d   [N_STATES];
    surv_t               sv_q   [N_STATES];
    surv_t               sv_d   [N_STATES];
    logic [N_STATES-1:0] msb;
    logic                norm;
    logic [FILL_W-1:0]   fill_q;
    logic                acc_q;
    logic [2:0]          best;
    metric_t             best_pm;

    // Hamming distance between the received pair and the pair emitted on pred -> {u, pred[2:1]}.
    function automatic metric_t branch_metric(input logic [1:0] code, input logic [2:0] pred,
                                              input logic u);
        logic [1:0] diff;
        diff = code ^ {u ^ pred[1] ^ pred[0], u ^ pred[2] ^ pred[1] ^ pred[0]};
        return metric_t'(diff[1]) + metric_t'(diff[0]);
    endfunction

    for (genvar g = 0; g < N_STATES; g++) begin : g_acs
        localparam logic [2:0] NS = 3'(g);
        localparam logic [2:0] P0 = {NS[1:0], 1'b0};
        localparam logic [2:0] P1 = {NS[1:0], 1'b1};
        metric_t c0;
        metric_t c1;
        logic    take_p1;

        assign c0         = pm_q[P0] + branch_metric(code_sig, P0, NS[2]);
        assign c1         = pm_q[P1] + branch_metric(code_sig, P1, NS[2]);
        // Strict compare so a tie keeps the even predecessor.
        assign take_p1    = (c1 < c0);
        assign pm_acs[g]  = take_p1 ? c1 : c0;
        assign sv_d[g]    = take_p1 ? {sv_q[P1][TB_DEPTH-2:0], NS[2]}
                                    : {sv_q[P0][TB_DEPTH-2:0], NS[2]};
        assign msb[g]     = pm_acs[g][METRIC_W-1];
        assign pm_d[g]    = norm ? {1'b0, pm_acs[g][METRIC_W-2:0]} : pm_acs[g];
    end

    // Subtracting the same offset from every metric keeps the ordering intact.
    assign norm = &msb;

    // NOTE: every variable written here gets a value before the loop, so no latch is inferred.
    always_comb begin
        best    = 3'd0;
        best_pm = pm_q[0];
        for (int i = 1; i < N_STATES; i++) begin
            if (pm_q[i] < best_pm) begin
                best    = 3'(i);
                best_pm = pm_q[i];
            end
        end
    end

    // NOTE: the survivor array is reset on purpose: a cleared history decodes as zeros, which
    // matches the encoder's all-zero start state.
    always_ff @(posedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) begin
            for (int i = 0; i < N_STATES; i++) begin
                pm_q[i] <= (i == 0) ? metric_t'(0) : metric_t'(16);
                sv_q[i] <= '0;
            end
            fill_q        <= '0;
            acc_q         <= 1'b0;
            dec_sig       <= 1'b0;
            dec_valid_sig <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read below sees the pre-edge state.
            acc_q         <= code_valid_sig;
            dec_valid_sig <= 1'b0;
            if (acc_q) begin
                dec_sig       <= sv_q[best][TB_DEPTH-1];
                dec_valid_sig <= (fill_q >= FILL_W'(TB_DEPTH));
            end
            if (code_valid_sig) begin
                pm_q <= pm_d;
                sv_q <= sv_d;
                if (fill_q != FILL_W'(TB_DEPTH)) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_decode.sv
// Self-checking bench for viterbi_decode: a reference encoder feeds the decoder and a queue of
// source bits is popped on every decoded strobe.
module tb_viterbi_decode;

    localparam int TB_DEPTH = 20;
    localparam int METRIC_W = 6;

    logic       clk_sig;
    logic       rst_sig;
    logic [1:0] code_sig;
    logic       code_valid_sig;
    logic       dec_sig;
    logic       dec_valid_sig;

    int   n_checks;
    int   n_fail;
    bit   exp_q[$];
    logic [2:0] enc_st;
    int   m_fill;
    bit   pend_v;
    bit   pend_ok;

    viterbi_decode #(.TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W)) dut (
        .clk_sig       (clk_sig),
        .rst_sig       (rst_sig),
        .code_sig      (code_sig),
        .code_valid_sig(code_valid_sig),
        .dec_sig       (dec_sig),
        .dec_valid_sig (dec_valid_sig)
    );

    initial clk_sig = 1'b0;
    always #5 clk_sig = ~clk_sig;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    // Encoder state is {u[k-1], u[k-2], u[k-3]}; outputs follow the octal 13 / 17 taps.
    task automatic encode(input logic u, output logic [1:0] pair);
        pair   = {u ^ enc_st[1] ^ enc_st[0], u ^ enc_st[2] ^ enc_st[1] ^ enc_st[0]};
        enc_st = {u, enc_st[2:1]};
    endtask

    task automatic reset_model();
        enc_st  = 3'b000;
        exp_q.delete();
        m_fill  = 0;
        pend_v  = 1'b0;
        pend_ok = 1'b0;
    endtask

    task automatic do_reset();
        rst_sig        = 1'b0;
        code_valid_sig = 1'b0;
        code_sig       = 2'b00;
        @(negedge clk_sig);
        rst_sig = 1'b1;
        reset_model();
    endtask

    // Drives one cycle from a falling edge to the next and returns the outputs seen after the
    // rising edge, plus the strobe the model predicts for that edge.
    task automatic drive_cycle(input logic v, input logic [1:0] code, input logic u,
                               output logic ov, output logic od, output logic ev);
        code_valid_sig = v;
        code_sig       = code;
        ev             = pend_v && pend_ok;
        if (v) begin
            exp_q.push_back(u);
            if (m_fill < TB_DEPTH) m_fill++;
        end
        pend_v  = v;
        pend_ok = (m_fill >= TB_DEPTH);
        @(posedge clk_sig);
        @(negedge clk_sig);
        ov = dec_valid_sig;
        od = dec_sig;
    endtask

    task automatic test_reset();
        logic ov, od, ev;
        rst_sig        = 1'b0;
        code_valid_sig = 1'b0;
        code_sig       = 2'b00;
        reset_model();
        @(negedge clk_sig);
        n_checks++;
        if (dec_valid_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: dec_valid_sig=%b expected 0", dec_valid_sig);
        end
        n_checks++;
        if (dec_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dec: dec_sig=%b expected 0", dec_sig);
        end
        rst_sig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 2'b11, 1'b0, ov, od, ev);
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: dec_valid_sig=%b expected %b", i, ov, ev);
            end
        end
    endtask

    task automatic test_all_zero();
        logic ov, od, ev;
        bit   exp_bit;
        int   strobes;
        int   first_idx;
        do_reset();
        strobes   = 0;
        first_idx = -1;
        for (int i = 0; i < 102; i++) begin
            if (i < 100) drive_cycle(1'b1, 2'b00, 1'b0, ov, od, ev);
            else         drive_cycle(1'b0, 2'b00, 1'b0, ov, od, ev);
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL zero_valid cyc=%0d: dec_valid_sig=%b expected %b", i, ov, ev);
            end
            if (ov === 1'b1) begin
                if (first_idx < 0) first_idx = i;
                strobes++;
                exp_bit = 1'b1;
                if (exp_q.size() > 0) exp_bit = exp_q.pop_front();
                n_checks++;
                if (od !== exp_bit || exp_bit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_data cyc=%0d: dec_sig=%b expected 0", i, od);
                end
            end
        end
        n_checks++;
        if (first_idx != TB_DEPTH) begin
            n_fail++;
            $display("FAIL zero_first_strobe: seen in cycle %0d expected %0d", first_idx, TB_DEPTH);
        end
        n_checks++;
        if (strobes != 81) begin
            n_fail++;
            $display("FAIL zero_strobe_count: got %0d expected 81", strobes);
        end
    endtask

    task automatic test_impulse();
        logic       ov, od, ev;
        logic [1:0] pair;
        logic       u;
        bit         exp_bit;
        int         strobes;
        do_reset();
        strobes = 0;
        for (int i = 0; i < 62; i++) begin
            if (i < 60) begin
                u = (i == 0);
                encode(u, pair);
                drive_cycle(1'b1, pair, u, ov, od, ev);
            end else begin
                drive_cycle(1'b0, 2'b00, 1'b0, ov, od, ev);
            end
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL impulse_valid cyc=%0d: dec_valid_sig=%b expected %b", i, ov, ev);
            end
            if (ov === 1'b1) begin
                exp_bit = 1'bx;
                if (exp_q.size() > 0) exp_bit = exp_q.pop_front();
                n_checks++;
                if (od !== exp_bit || (strobes == 0 && exp_bit !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL impulse_data strobe=%0d: dec_sig=%b expected %b", strobes, od, exp_bit);
                end
                strobes++;
            end
        end
        n_checks++;
        if (strobes != 41) begin
            n_fail++;
            $display("FAIL impulse_strobe_count: got %0d expected 41", strobes);
        end
    endtask

    task automatic test_random_errors();
        logic       ov, od, ev;
        logic [1:0] pair;
        logic       u;
        bit         exp_bit;
        int         strobes;
        do_reset();
        strobes = 0;
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) begin
                u = 1'($urandom);
                encode(u, pair);
                if (i % 10 == 5) pair[$urandom_range(1, 0)] ^= 1'b1;
                drive_cycle(1'b1, pair, u, ov, od, ev);
            end else begin
                drive_cycle(1'b0, 2'b00, 1'b0, ov, od, ev);
            end
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL errors_valid cyc=%0d: dec_valid_sig=%b expected %b", i, ov, ev);
            end
            if (ov === 1'b1) begin
                strobes++;
                exp_bit = 1'bx;
                if (exp_q.size() > 0) exp_bit = exp_q.pop_front();
                n_checks++;
                if (od !== exp_bit) begin
                    n_fail++;
                    $display("FAIL errors_data strobe=%0d: dec_sig=%b expected %b", strobes, od, exp_bit);
                end
            end
        end
        n_checks++;
        if (strobes != 981) begin
            n_fail++;
            $display("FAIL errors_strobe_count: got %0d expected 981", strobes);
        end
    endtask

    task automatic test_gapped();
        logic       ov, od, ev;
        logic [1:0] pair;
        logic       u;
        logic       v;
        logic       prev_idle;
        bit         exp_bit;
        int         accepted;
        int         strobes;
        int         cyc;
        do_reset();
        accepted  = 0;
        strobes   = 0;
        cyc       = 0;
        prev_idle = 1'b1;
        while (accepted < 500 || cyc < 2 || !prev_idle) begin
            v = (accepted < 500) ? 1'($urandom) : 1'b0;
            if (v) begin
                u = 1'($urandom);
                encode(u, pair);
                accepted++;
                drive_cycle(1'b1, pair, u, ov, od, ev);
            end else begin
                drive_cycle(1'b0, 2'($urandom), 1'b0, ov, od, ev);
            end
            n_checks++;
            if (ov !== ev || (prev_idle && ov !== 1'b0)) begin
                n_fail++;
                $display("FAIL gapped_valid cyc=%0d: dec_valid_sig=%b expected %b", cyc, ov,
                         prev_idle ? 1'b0 : ev);
            end
            if (ov === 1'b1) begin
                strobes++;
                exp_bit = 1'bx;
                if (exp_q.size() > 0) exp_bit = exp_q.pop_front();
                n_checks++;
                if (od !== exp_bit) begin
                    n_fail++;
                    $display("FAIL gapped_data strobe=%0d: dec_sig=%b expected %b", strobes, od, exp_bit);
                end
            end
            prev_idle = !v;
            cyc++;
        end
        n_checks++;
        if (strobes != 481) begin
            n_fail++;
            $display("FAIL gapped_strobe_count: got %0d expected 481", strobes);
        end
    endtask

    task automatic test_midstream_reset();
        logic       ov, od, ev;
        logic [1:0] pair;
        logic       u;
        bit         exp_bit;
        int         strobes;
        int         first_idx;
        do_reset();
        for (int i = 0; i < 37; i++) begin
            u = 1'($urandom);
            encode(u, pair);
            drive_cycle(1'b1, pair, u, ov, od, ev);
        end
        rst_sig        = 1'b0;
        code_valid_sig = 1'b0;
        #1;
        n_checks++;
        if (dec_valid_sig !== 1'b0 || dec_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: dec_valid_sig=%b dec_sig=%b expected 0 0",
                     dec_valid_sig, dec_sig);
        end
        @(negedge clk_sig);
        rst_sig = 1'b1;
        reset_model();
        strobes   = 0;
        first_idx = -1;
        for (int i = 0; i < 32; i++) begin
            if (i < 30) begin
                u = 1'($urandom);
                encode(u, pair);
                drive_cycle(1'b1, pair, u, ov, od, ev);
            end else begin
                drive_cycle(1'b0, 2'b00, 1'b0, ov, od, ev);
            end
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL midreset_valid cyc=%0d: dec_valid_sig=%b expected %b", i, ov, ev);
            end
            if (ov === 1'b1) begin
                if (first_idx < 0) first_idx = i;
                strobes++;
                exp_bit = 1'bx;
                if (exp_q.size() > 0) exp_bit = exp_q.pop_front();
                n_checks++;
                if (od !== exp_bit) begin
                    n_fail++;
                    $display("FAIL midreset_data strobe=%0d: dec_sig=%b expected %b", strobes, od, exp_bit);
                end
            end
        end
        n_checks++;
        if (first_idx != TB_DEPTH || strobes != 11) begin
            n_fail++;
            $display("FAIL midreset_restart: first strobe cycle %0d count %0d expected %0d and 11",
                     first_idx, strobes, TB_DEPTH);
        end
    endtask

    task automatic test_long_run();
        logic       ov, od, ev;
        logic [1:0] pair;
        logic       u;
        bit         exp_bit;
        int         strobes;
        int         errors;
        do_reset();
        strobes = 0;
        errors  = 0;
        for (int i = 0; i < 10002; i++) begin
            if (i < 10000) begin
                u = 1'($urandom);
                encode(u, pair);
                drive_cycle(1'b1, pair, u, ov, od, ev);
            end else begin
                drive_cycle(1'b0, 2'b00, 1'b0, ov, od, ev);
            end
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL long_valid cyc=%0d: dec_valid_sig=%b expected %b", i, ov, ev);
            end
            if (ov === 1'b1) begin
                strobes++;
                exp_bit = 1'bx;
                if (exp_q.size() > 0) exp_bit = exp_q.pop_front();
                n_checks++;
                if (od !== exp_bit) begin
                    n_fail++;
                    errors++;
                    if (errors <= 10)
                        $display("FAIL long_data strobe=%0d: dec_sig=%b expected %b", strobes, od, exp_bit);
                end
            end
        end
        n_checks++;
        if (strobes != 9981) begin
            n_fail++;
            $display("FAIL long_strobe_count: got %0d expected 9981", strobes);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_sig        = 1'b0;
        code_valid_sig = 1'b0;
        code_sig       = 2'b00;
        test_reset();
        test_all_zero();
        test_impulse();
        test_random_errors();
        test_gapped();
        test_midstream_reset();
        test_long_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
